// File: rtl/axi_interconnect_fifogen_wptr_gray_pkg.sv
// Shared pointer helpers for the async FIFO write side.
// Provides the gray/binary conversions and the pointer-width rule.
package axi_interconnect_fifogen_wptr_gray_pkg;

  localparam int AW_DFLT = 4;

  typedef struct packed {
    logic full;
    logic afull;
    logic overflow;
  } wflag_t;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Callers zero-extend, so the prefix XOR from bit 31 downward is exact.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/axi_interconnect_fifogen_dec2gray.sv
// Binary-to-gray encoder; combinational when PIPLE_LINE is 0, otherwise one register stage.
// No flow control: the output follows the input.
module axi_interconnect_fifogen_dec2gray
  import axi_interconnect_fifogen_wptr_gray_pkg::*;
#(
  parameter int DW         = 5,
  parameter int PIPLE_LINE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_bin,
  output logic [DW-1:0] o_gray
);

  logic [DW-1:0] w_gray;

  assign w_gray = DW'(bin2gray(32'(i_bin)));

  generate
    if (PIPLE_LINE == 0) begin : g_comb
      logic w_unused;
      assign w_unused = ^{clk, rst_n};
      assign o_gray   = w_gray;
    end else begin : g_reg
      logic [DW-1:0] r_gray;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_gray <= '0;
        end else begin
          r_gray <= w_gray;
        end
      end
      assign o_gray = r_gray;
    end
  endgenerate

endmodule

// File: rtl/axi_interconnect_fifogen_wptr_gray.sv
// Async FIFO write-side pointer/flag generator: binary write pointer, registered gray pointer, full/afull/level.
// mem_we is combinational; the gray pointer and flags update one clk_sys edge after a push; pushes while full are dropped.
module axi_interconnect_fifogen_wptr_gray
  import axi_interconnect_fifogen_wptr_gray_pkg::*;
#(
  parameter int AW       = AW_DFLT,
  parameter int AFULL_TH = (2**AW) - 2
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gray_sync,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [AW:0]   wr_gray,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wr_level,
  output logic          overflow
);

  localparam int               PTR_W   = ptr_w(AW);
  localparam logic [PTR_W-1:0] AFULL_V = PTR_W'(AFULL_TH);

  logic [PTR_W-1:0] r_wr_bin;
  logic [PTR_W-1:0] r_wr_gray;
  logic [PTR_W-1:0] r_level;
  wflag_t           r_flag;

  logic             w_accept;
  logic [PTR_W-1:0] w_wr_bin_nxt;
  logic [PTR_W-1:0] w_wr_gray_nxt;
  logic [PTR_W-1:0] w_rd_bin;
  logic [PTR_W-1:0] w_full_ref;
  logic [PTR_W-1:0] w_level_nxt;
  wflag_t           w_flag_nxt;

  assign w_accept     = wr_en & ~r_flag.full;
  assign w_wr_bin_nxt = r_wr_bin + PTR_W'(w_accept);

  axi_interconnect_fifogen_dec2gray #(
    .DW         (PTR_W),
    .PIPLE_LINE (0)
  ) u_dec2gray (
    .clk    (clk_sys),
    .rst_n  (rst_n),
    .i_bin  (w_wr_bin_nxt),
    .o_gray (w_wr_gray_nxt)
  );

  assign w_rd_bin = PTR_W'(gray2bin(32'(rd_gray_sync)));

  // Gray of (rd + 2**AW): top two gray bits inverted, the rest unchanged.
  assign w_full_ref  = {~rd_gray_sync[AW:AW-1], rd_gray_sync[AW-2:0]};
  assign w_level_nxt = w_wr_bin_nxt - w_rd_bin;

  always_comb begin
    w_flag_nxt          = '0;
    w_flag_nxt.full     = (w_wr_gray_nxt == w_full_ref);
    w_flag_nxt.afull    = (w_level_nxt >= AFULL_V);
    w_flag_nxt.overflow = wr_en & r_flag.full;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
      r_level   <= '0;
      r_flag    <= '0;
    end else begin
      r_wr_bin  <= w_wr_bin_nxt;
      r_wr_gray <= w_wr_gray_nxt;
      r_level   <= w_level_nxt;
      r_flag    <= w_flag_nxt;
    end
  end

  assign mem_we    = w_accept;
  assign mem_waddr = r_wr_bin[AW-1:0];
  assign wr_gray   = r_wr_gray;
  assign full      = r_flag.full;
  assign afull     = r_flag.afull;
  assign wr_level  = r_level;
  assign overflow  = r_flag.overflow;

endmodule
